// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory between two masters,
// with a registered command stage and a two-stage tag pipeline routing read data to its owner.
module dmem_arbiter #(
  parameter int ADDR_DEPTH = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_DEPTH-1:0] A_ADDR,
  input  logic [31:0]           A_WDATA,
  input  logic [1:0]            A_BYTE_SEL,
  input  logic                  A_SIGN,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_DEPTH-1:0] B_ADDR,
  input  logic [31:0]           B_WDATA,
  input  logic [1:0]            B_BYTE_SEL,
  input  logic                  B_SIGN,
  output logic                  A_GNT,
  output logic                  B_GNT,
  output logic                  A_RVALID,
  output logic                  B_RVALID,
  output logic [31:0]           A_RDATA,
  output logic [31:0]           B_RDATA,
  output logic                  M_RDEN,
  output logic                  M_WEN,
  output logic [ADDR_DEPTH-1:0] M_ADDR,
  output logic [31:0]           M_DATA_IN,
  output logic [1:0]            M_BYTE_SEL,
  output logic                  M_SIGN,
  input  logic [31:0]           M_DATA_OUT
);
  // last_q = 1 means port B was granted most recently
  logic last_q, last_d;
  logic gnt, we_w, resp_v;
  logic m_rden_q, m_rden_d, m_wen_q, m_wen_d, m_sign_q, m_sign_d;
  logic [ADDR_DEPTH-1:0] m_addr_q, m_addr_d;
  logic [31:0] m_data_q, m_data_d;
  logic [1:0] m_bsel_q, m_bsel_d;
  logic s1_v_q, s1_v_d, s1_own_q, s1_own_d, s1_rd_q, s1_rd_d;
  logic s2_v_q, s2_own_q, s2_rd_q;
  assign A_GNT = A_REQ & (~B_REQ | last_q);
  assign B_GNT = B_REQ & (~A_REQ | ~last_q);
  assign gnt   = A_GNT | B_GNT;
  assign we_w  = B_GNT ? B_WE : A_WE;
  always_comb begin
    last_d   = gnt ? B_GNT : last_q;
    m_rden_d = gnt & ~we_w;
    m_wen_d  = gnt & we_w;
    m_addr_d = gnt ? (B_GNT ? B_ADDR : A_ADDR) : m_addr_q;
    m_data_d = gnt ? (B_GNT ? B_WDATA : A_WDATA) : m_data_q;
    m_bsel_d = gnt ? (B_GNT ? B_BYTE_SEL : A_BYTE_SEL) : m_bsel_q;
    m_sign_d = gnt ? (B_GNT ? B_SIGN : A_SIGN) : m_sign_q;
    s1_v_d   = gnt;
    s1_own_d = B_GNT;
    s1_rd_d  = ~we_w;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q   <= 1'b1;
      m_rden_q <= 1'b0;
      m_wen_q  <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
      m_bsel_q <= '0;
      m_sign_q <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_own_q <= 1'b0;
      s1_rd_q  <= 1'b0;
      s2_v_q   <= 1'b0;
      s2_own_q <= 1'b0;
      s2_rd_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      m_rden_q <= m_rden_d;
      m_wen_q  <= m_wen_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      m_bsel_q <= m_bsel_d;
      m_sign_q <= m_sign_d;
      s1_v_q   <= s1_v_d;
      s1_own_q <= s1_own_d;
      s1_rd_q  <= s1_rd_d;
      s2_v_q   <= s1_v_q;
      s2_own_q <= s1_own_q;
      s2_rd_q  <= s1_rd_q;
    end
  end
  assign resp_v     = s2_v_q & s2_rd_q;
  assign A_RVALID   = resp_v & ~s2_own_q;
  assign B_RVALID   = resp_v & s2_own_q;
  assign A_RDATA    = A_RVALID ? M_DATA_OUT : '0;
  assign B_RDATA    = B_RVALID ? M_DATA_OUT : '0;
  assign M_RDEN     = m_rden_q;
  assign M_WEN      = m_wen_q;
  assign M_ADDR     = m_addr_q;
  assign M_DATA_IN  = m_data_q;
  assign M_BYTE_SEL = m_bsel_q;
  assign M_SIGN     = m_sign_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a queue-based transaction model plus a behavioural memory.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int NPRE = 9;
  localparam logic [15:0] PRE_A [NPRE] = '{16'h6004, 16'h6008, 16'h6020, 16'h6024, 16'h6030,
                                           16'h6034, 16'h6040, 16'h6044, 16'h6010};
  localparam logic [31:0] PRE_D [NPRE] = '{32'hDEADBEEF, 32'h22222222, 32'hA0A0A0A0, 32'hA1A1A1A1,
                                           32'hB0B0B0B0, 32'hB1B1B1B1, 32'h000000A5, 32'hDEADBEEF,
                                           32'h00000000};
  typedef struct packed { logic we; logic [AW-1:0] addr; logic [31:0] wd; logic [1:0] bs; logic sg; } cmd_t;
  typedef struct packed { int due; int port; logic [31:0] data; } rsp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic a_req, a_we, a_sign, b_req, b_we, b_sign;
  logic [AW-1:0] a_addr, b_addr, m_addr;
  logic [31:0] a_wd, b_wd, a_rd, b_rd, m_din;
  logic [1:0] a_bs, b_bs, m_bs;
  logic a_gnt, b_gnt, a_rv, b_rv, m_rden, m_wen, m_sign;
  logic [31:0] m_dout = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  cmd_t aq[$], bq[$];
  rsp_t rq[$];
  logic [31:0] dev_mem [0:65535];
  logic [31:0] mdl_mem [0:65535];
  int m_last, mw;
  cmd_t mc;
  logic em_rd, em_wr, em_sg;
  logic [AW-1:0] em_addr;
  logic [31:0] em_din;
  logic [1:0] em_bs;
  int g_port[$], g_cyc[$], r_port[$], r_cyc[$], c_cyc[$];
  logic [31:0] r_data[$];
  logic [AW-1:0] c_addr[$];

  dmem_arbiter #(.ADDR_DEPTH(AW)) dut (
    .CLK(clk), .RST(rst),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wd), .A_BYTE_SEL(a_bs), .A_SIGN(a_sign),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wd), .B_BYTE_SEL(b_bs), .B_SIGN(b_sign),
    .A_GNT(a_gnt), .B_GNT(b_gnt), .A_RVALID(a_rv), .B_RVALID(b_rv), .A_RDATA(a_rd), .B_RDATA(b_rd),
    .M_RDEN(m_rden), .M_WEN(m_wen), .M_ADDR(m_addr), .M_DATA_IN(m_din), .M_BYTE_SEL(m_bs),
    .M_SIGN(m_sign), .M_DATA_OUT(m_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] bs, input logic sg);
    if (bs == 2'b00) return sg ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
    if (bs == 2'b01) return sg ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
    return w;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [1:0] bs);
    if (bs == 2'b00) return {o[31:8], d[7:0]};
    if (bs == 2'b01) return {o[31:16], d[15:0]};
    return d;
  endfunction
  function automatic cmd_t rd(input logic [AW-1:0] a, input logic [1:0] bs, input logic sg);
    return {1'b0, a, 32'h0, bs, sg};
  endfunction
  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [31:0] d);
    return {1'b1, a, d, 2'b10, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory device: registered read data, one-cycle write commit
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPRE; i++) dev_mem[PRE_A[i]] <= PRE_D[i];
    end else begin
      if (m_wen) dev_mem[m_addr] <= merge(dev_mem[m_addr], m_din, m_bs);
      if (m_rden) m_dout <= fmt(dev_mem[m_addr], m_bs, m_sign);
    end
  end

  // Model: winner by round-robin rule; reads scheduled two cycles after acceptance
  always_comb begin
    mw = (a_req && b_req) ? (m_last == 1 ? 0 : 1) : a_req ? 0 : b_req ? 1 : -1;
    mc = (mw == 1) ? {b_we, b_addr, b_wd, b_bs, b_sign} : {a_we, a_addr, a_wd, a_bs, a_sign};
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last <= 1;
      em_rd <= 1'b0;
      em_wr <= 1'b0;
      em_addr <= '0;
      em_din <= '0;
      em_bs <= '0;
      em_sg <= 1'b0;
      rq.delete();
      for (int i = 0; i < NPRE; i++) mdl_mem[PRE_A[i]] <= PRE_D[i];
    end else if (mw >= 0) begin
      m_last <= mw;
      em_rd <= !mc.we;
      em_wr <= mc.we;
      em_addr <= mc.addr;
      em_din <= mc.wd;
      em_bs <= mc.bs;
      em_sg <= mc.sg;
      if (mc.we) mdl_mem[mc.addr] <= merge(mdl_mem[mc.addr], mc.wd, mc.bs);
      else rq.push_back('{cyc + 2, mw, fmt(mdl_mem[mc.addr], mc.bs, mc.sg)});
    end else begin
      em_rd <= 1'b0;
      em_wr <= 1'b0;
    end
  end

  // Compare process
  initial begin
    rsp_t e;
    logic ev;
    forever begin
      @(negedge clk);
      chk("a_gnt", a_gnt, mw == 0);
      chk("b_gnt", b_gnt, mw == 1);
      chk("m_rden", m_rden, em_rd);
      chk("m_wen", m_wen, em_wr);
      chk("rden_wen_excl", m_rden & m_wen, 0);
      if (em_rd || em_wr) begin
        chk("m_addr", m_addr, em_addr);
        chk("m_byte_sel", m_bs, em_bs);
        chk("m_sign", m_sign, em_sg);
        if (em_wr) chk("m_data_in", m_din, em_din);
      end
      ev = 1'b0;
      e = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        ev = 1'b1;
      end
      chk("a_rvalid", a_rv, ev && e.port == 0);
      chk("b_rvalid", b_rv, ev && e.port == 1);
      chk("a_rdata", a_rd, (ev && e.port == 0) ? e.data : 32'h0);
      chk("b_rdata", b_rd, (ev && e.port == 1) ? e.data : 32'h0);
      if (!rst && a_req && a_gnt) begin g_port.push_back(0); g_cyc.push_back(cyc); end
      if (!rst && b_req && b_gnt) begin g_port.push_back(1); g_cyc.push_back(cyc); end
      if (m_rden || m_wen) begin c_addr.push_back(m_addr); c_cyc.push_back(cyc); end
      if (a_rv) begin r_port.push_back(0); r_data.push_back(a_rd); r_cyc.push_back(cyc); end
      if (b_rv) begin r_port.push_back(1); r_data.push_back(b_rd); r_cyc.push_back(cyc); end
    end
  end

  // Masters: present queue head, hold it until granted
  initial begin
    logic hit;
    {a_req, a_we, a_addr, a_wd, a_bs, a_sign} = '0;
    forever begin
      @(negedge clk);
      hit = a_req && a_gnt && !rst;
      @(posedge clk);
      #1;
      if (hit) void'(aq.pop_front());
      a_req = aq.size() > 0;
      if (a_req) {a_we, a_addr, a_wd, a_bs, a_sign} = aq[0];
    end
  end
  initial begin
    logic hit;
    {b_req, b_we, b_addr, b_wd, b_bs, b_sign} = '0;
    forever begin
      @(negedge clk);
      hit = b_req && b_gnt && !rst;
      @(posedge clk);
      #1;
      if (hit) void'(bq.pop_front());
      b_req = bq.size() > 0;
      if (b_req) {b_we, b_addr, b_wd, b_bs, b_sign} = bq[0];
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (k < 60) begin
      @(posedge clk);
      if (aq.size() == 0 && bq.size() == 0 && rq.size() == 0 && !a_req && !b_req) break;
      k++;
    end
    chk("idle_timeout", k < 60, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    int gb, rb, k;
    aq.push_back(rd(16'h6004, 2'b10, 1'b0));
    bq.push_back(rd(16'h6008, 2'b10, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_a_gnt", a_gnt, 1);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_m_rden", m_rden, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data_in", m_din, 0);
    chk("rst_a_rvalid", a_rv, 0);
    chk("rst_b_rdata", b_rd, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle();
    chk("first_tie_port", g_port[0], 0);
    chk("second_port", g_port[1], 1);
    chk("cmd_addr", c_addr[0], 16'h6004);
    chk("cmd_latency", c_cyc[0] - g_cyc[0], 1);
    chk("read_latency", r_cyc[0] - g_cyc[0], 2);
    chk("single_owner", r_port[0], 0);
    chk("single_data", r_data[0], 32'hDEADBEEF);
    chk("b_data", r_data[1], 32'h22222222);

    gb = g_port.size();
    rb = r_port.size();
    aq.push_back(rd(16'h6020, 2'b10, 1'b0));
    aq.push_back(rd(16'h6024, 2'b10, 1'b0));
    bq.push_back(rd(16'h6030, 2'b10, 1'b0));
    bq.push_back(rd(16'h6034, 2'b10, 1'b0));
    wait_idle();
    chk("cont_g0", g_port[gb], 0);
    chk("cont_g1", g_port[gb+1], 1);
    chk("cont_g2", g_port[gb+2], 0);
    chk("cont_g3", g_port[gb+3], 1);
    chk("cont_span", g_cyc[gb+3] - g_cyc[gb], 3);
    chk("cont_r0", r_data[rb], 32'hA0A0A0A0);
    chk("cont_r1", r_data[rb+1], 32'hB0B0B0B0);
    chk("cont_r2", r_data[rb+2], 32'hA1A1A1A1);
    chk("cont_r3", r_data[rb+3], 32'hB1B1B1B1);
    chk("cont_owner3", r_port[rb+3], 1);

    gb = g_port.size();
    rb = r_port.size();
    bq.push_back(wr(16'h6010, 32'h12345678));
    @(posedge clk);
    @(negedge clk);
    #2;
    aq.push_back(rd(16'h6010, 2'b10, 1'b0));
    wait_idle();
    chk("wr_grant_b", g_port[gb], 1);
    chk("rd_grant_a", g_port[gb+1], 0);
    chk("raw_data", r_data[rb], 32'h12345678);
    chk("raw_latency", r_cyc[rb] - g_cyc[gb], 3);

    bq.push_back(wr(16'h6050, 32'h00000055));
    wait_idle();
    gb = g_port.size();
    rb = r_port.size();
    aq.push_back(rd(16'h6040, 2'b00, 1'b0));
    bq.push_back(rd(16'h6044, 2'b01, 1'b1));
    wait_idle();
    chk("byte_first_a", g_port[gb], 0);
    chk("byte_data", r_data[rb], 32'h000000A5);
    chk("held_b_owner", r_port[rb+1], 1);
    chk("held_b_half", r_data[rb+1], 32'hFFFFBEEF);

    gb = g_port.size();
    rb = r_port.size();
    aq.push_back(rd(16'h6004, 2'b10, 1'b0));
    k = 0;
    while (k < 20 && g_port.size() == gb) begin
      @(posedge clk);
      k++;
    end
    chk("mid_grant_seen", g_port.size() > gb, 1);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("no_rvalid_after_rst", r_port.size(), rb);
    @(negedge clk);
    #2;
    aq.push_back(rd(16'h6008, 2'b10, 1'b0));
    wait_idle();
    chk("post_rst_owner", r_port[rb], 0);
    chk("post_rst_data", r_data[rb], 32'h22222222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
